// File: rtl/winograd_io_pkg.sv
// Shared encodings, header layout and FSM states
// for the Winograd pad bridge.
package winograd_io_pkg;

  localparam logic KIND_DATA   = 1'b0;
  localparam logic KIND_WEIGHT = 1'b1;

  localparam int HDR_KIND_BIT = 0;
  localparam int HDR_RSVD_LSB = 1;

  function automatic int bpw_f(int data_w, int pad_w);
    return (data_w + pad_w - 1) / pad_w;
  endfunction

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_COLLECT,
    RX_HOLD
  } rx_state_t;

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_t;

endpackage

// File: rtl/pad_serializer.sv
// Core result tile to pad beats, LS slice first,
// top slice of each word sign-extended.
module pad_serializer
  import winograd_io_pkg::*;
#(
  parameter int PAD_W  = 10,
  parameter int DATA_W = 16,
  parameter int N_OUT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_OUT*DATA_W-1:0] out_data,
  input  logic                    out_valid,
  output logic                    out_ready,
  output logic [PAD_W-1:0]        Z,
  output logic                    Z_vld
);

  localparam int BPW   = bpw_f(DATA_W, PAD_W);
  localparam int WBITS = BPW * PAD_W;
  localparam int NB    = N_OUT * BPW;
  localparam int CW    = $clog2(NB + 1);

  tx_state_t           st;
  logic [NB*PAD_W-1:0] ext;
  logic [NB*PAD_W-1:0] sh;
  logic [CW-1:0]       cnt;

  // Each word widened to whole beats before capture
  always_comb begin
    ext = '0;
    for (int w = 0; w < N_OUT; w++) begin
      for (int i = 0; i < WBITS; i++) begin
        if (i < DATA_W)
          ext[w*WBITS+i] = out_data[w*DATA_W+i];
        else
          ext[w*WBITS+i] = out_data[w*DATA_W+DATA_W-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= TX_IDLE;
      sh        <= '0;
      cnt       <= '0;
      Z         <= '0;
      Z_vld     <= 1'b0;
      out_ready <= 1'b1;
    end else begin
      unique case (st)
        TX_IDLE: begin
          if (out_valid && out_ready) begin
            sh        <= ext >> PAD_W;
            Z         <= ext[PAD_W-1:0];
            Z_vld     <= 1'b1;
            out_ready <= 1'b0;
            cnt       <= '0;
            st        <= TX_SEND;
          end
        end
        TX_SEND: begin
          if (cnt == CW'(NB - 1)) begin
            Z         <= '0;
            Z_vld     <= 1'b0;
            out_ready <= 1'b1;
            st        <= TX_IDLE;
          end else begin
            Z   <= sh[PAD_W-1:0];
            sh  <= sh >> PAD_W;
            cnt <= cnt + 1'b1;
          end
        end
        default: st <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/winograd_pad_bridge.sv
// Pad-bus bridge for a Winograd core: framed RX
// deserialiser plus TX serialiser.
module winograd_pad_bridge
  import winograd_io_pkg::*;
#(
  parameter int PAD_W  = 10,
  parameter int DATA_W = 16,
  parameter int N_IN   = 6,
  parameter int N_W    = 3,
  parameter int N_OUT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PAD_W-1:0]        D,
  input  logic                    D_vld,
  output logic                    D_rdy,
  output logic [PAD_W-1:0]        Z,
  output logic                    Z_vld,
  output logic [N_IN*DATA_W-1:0]  in_data,
  output logic                    in_kind,
  output logic                    in_valid,
  input  logic                    in_ready,
  input  logic [N_OUT*DATA_W-1:0] out_data,
  input  logic                    out_valid,
  output logic                    out_ready,
  output logic                    err_hdr,
  output logic                    err_ovf
);

  localparam int BPW = bpw_f(DATA_W, PAD_W);
  localparam int WW  = $clog2(N_IN + 1);
  localparam int BW  = $clog2(BPW + 1);

  if (PAD_W < 2) begin : g_chk_pad
    $error("PAD_W must be >= 2");
  end
  if (DATA_W < 2) begin : g_chk_data
    $error("DATA_W must be >= 2");
  end
  if (N_W > N_IN) begin : g_chk_nw
    $error("N_W must be <= N_IN");
  end

  rx_state_t             st;
  logic                  kind;
  logic [WW-1:0]         wi;
  logic [WW-1:0]         wlast;
  logic [BW-1:0]         bi;
  logic [N_IN*DATA_W-1:0] data_q;
  logic [DATA_W-1:0]     word_nx;
  logic                  beat;
  logic                  hdr_ok;

  assign beat   = D_vld && D_rdy;
  assign hdr_ok = (D[PAD_W-1:HDR_RSVD_LSB] == '0);

  assign in_data = data_q;
  assign in_kind = kind;

  // Beat bits landing above DATA_W are dropped
  always_comb begin
    word_nx = data_q[wi*DATA_W +: DATA_W];
    for (int j = 0; j < PAD_W; j++) begin
      if (int'(bi) * PAD_W + j < DATA_W)
        word_nx[int'(bi)*PAD_W+j] = D[j];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= RX_IDLE;
      kind     <= KIND_DATA;
      wi       <= '0;
      wlast    <= '0;
      bi       <= '0;
      data_q   <= '0;
      D_rdy    <= 1'b1;
      in_valid <= 1'b0;
      err_hdr  <= 1'b0;
      err_ovf  <= 1'b0;
    end else begin
      if (D_vld && !D_rdy)
        err_ovf <= 1'b1;
      unique case (st)
        RX_IDLE: begin
          if (beat) begin
            if (hdr_ok) begin
              kind   <= D[HDR_KIND_BIT];
              wlast  <= (D[HDR_KIND_BIT] == KIND_WEIGHT)
                        ? WW'(N_W - 1) : WW'(N_IN - 1);
              wi     <= '0;
              bi     <= '0;
              data_q <= '0;
              st     <= RX_COLLECT;
            end else begin
              err_hdr <= 1'b1;
            end
          end
        end
        RX_COLLECT: begin
          if (beat) begin
            data_q[wi*DATA_W +: DATA_W] <= word_nx;
            if (bi == BW'(BPW - 1)) begin
              bi <= '0;
              if (wi == wlast) begin
                st       <= RX_HOLD;
                D_rdy    <= 1'b0;
                in_valid <= 1'b1;
              end else begin
                wi <= wi + 1'b1;
              end
            end else begin
              bi <= bi + 1'b1;
            end
          end
        end
        RX_HOLD: begin
          if (in_ready) begin
            in_valid <= 1'b0;
            D_rdy    <= 1'b1;
            st       <= RX_IDLE;
          end
        end
        default: st <= RX_IDLE;
      endcase
    end
  end

  pad_serializer #(
    .PAD_W (PAD_W),
    .DATA_W(DATA_W),
    .N_OUT (N_OUT)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (Z),
    .Z_vld    (Z_vld)
  );

endmodule

// File: tb/tb_winograd_pad_bridge.sv
// Scoreboard bench for winograd_pad_bridge:
// directed RX frames and TX tiles.
module tb_winograd_pad_bridge;

  localparam int PAD_W  = 10;
  localparam int DATA_W = 16;
  localparam int N_IN   = 6;
  localparam int N_W    = 3;
  localparam int N_OUT  = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [PAD_W-1:0]        D;
  logic                    D_vld;
  logic                    D_rdy;
  logic [PAD_W-1:0]        Z;
  logic                    Z_vld;
  logic [N_IN*DATA_W-1:0]  in_data;
  logic                    in_kind;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_hdr;
  logic                    err_ovf;

  always #5 clk = ~clk;

  winograd_pad_bridge #(
    .PAD_W(PAD_W), .DATA_W(DATA_W),
    .N_IN(N_IN), .N_W(N_W), .N_OUT(N_OUT)
  ) dut (
    .clk(clk), .rst(rst),
    .D(D), .D_vld(D_vld), .D_rdy(D_rdy),
    .Z(Z), .Z_vld(Z_vld),
    .in_data(in_data), .in_kind(in_kind),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready),
    .err_hdr(err_hdr), .err_ovf(err_ovf)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int zcnt   = 0;

  logic [95:0] rx_q[$];
  logic        rxk_q[$];
  logic [9:0]  tx_q[$];
  logic [95:0] rx_e;
  logic        rx_k;
  logic [9:0]  tx_e;
  logic [95:0] e1, e2, e3, e4, e5, e6, ew;

  task automatic check(string name, logic [127:0] act,
                       logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      if (rx_q.size() == 0) begin
        check("rx_unexpected", 1'b1, 1'b0);
      end else begin
        rx_e = rx_q.pop_front();
        rx_k = rxk_q.pop_front();
        check("rx_data", in_data, rx_e);
        check("rx_kind", in_kind, rx_k);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && Z_vld) begin
      zcnt++;
      check("tx_busy_rdy", out_ready, 1'b0);
      if (tx_q.size() == 0) begin
        check("tx_unexpected", 1'b1, 1'b0);
      end else begin
        tx_e = tx_q.pop_front();
        check("tx_beat", Z, tx_e);
      end
    end
  end

  task automatic beat(input logic [PAD_W-1:0] v);
    D = v;
    D_vld = 1'b1;
    @(posedge clk); #1;
    D_vld = 1'b0;
    D = '0;
  endtask

  task automatic send_frame(input logic k,
                            input logic [95:0] w,
                            input int nw,
                            input logic [3:0] junk);
    rx_q.push_back(w);
    rxk_q.push_back(k);
    beat({9'd0, k});
    for (int i = 0; i < nw; i++) begin
      beat(w[i*16 +: 10]);
      beat({junk, w[i*16+10 +: 6]});
    end
  endtask

  task automatic frame_done(input logic k);
    check("lat_valid", in_valid, 1'b1);
    check("hold_rdy", D_rdy, 1'b0);
    check("hold_kind", in_kind, k);
    @(posedge clk); #1;
    check("rel_valid", in_valid, 1'b0);
    check("rel_rdy", D_rdy, 1'b1);
  endtask

  task automatic tx_send(input logic [63:0] d,
                         input logic [79:0] b);
    int t;
    for (int k = 0; k < 8; k++)
      tx_q.push_back(b[k*10 +: 10]);
    out_data = d;
    out_valid = 1'b1;
    t = 0;
    while (!out_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("tx_wait", t < 40, 1'b1);
    @(posedge clk); #1;
    out_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 6; i++) begin
      e1[i*16 +: 16] = 16'(i + 1);
      e2[i*16 +: 16] = 16'(16'h0100 + i);
      e3[i*16 +: 16] = 16'(16'h0007 + i);
      e4[i*16 +: 16] = 16'(16'hA000 + i * 16'h0411);
      e5[i*16 +: 16] = 16'(16'h7F00 - i);
      e6[i*16 +: 16] = 16'(16'h0C30 + i);
    end
    ew = {48'd0, 16'h8000, 16'h0002, 16'hFFFF};

    D = '0; D_vld = 1'b0; in_ready = 1'b1;
    out_data = '0; out_valid = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_D_rdy", D_rdy, 1'b1);
    check("rst_out_ready", out_ready, 1'b1);
    check("rst_in_valid", in_valid, 1'b0);
    check("rst_Z_vld", Z_vld, 1'b0);
    check("rst_Z", Z, 10'd0);
    check("rst_in_data", in_data, 96'd0);
    check("rst_err", {err_hdr, err_ovf}, 2'b00);
    rst = 1'b0;

    send_frame(1'b0, e1, 6, 4'h0);
    frame_done(1'b0);

    send_frame(1'b1, ew, 3, 4'h0);
    frame_done(1'b1);

    in_ready = 1'b0;
    send_frame(1'b0, e2, 6, 4'h0);
    check("ovf_pre", err_ovf, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", in_valid, 1'b1);
      check("bp_rdy", D_rdy, 1'b0);
      check("bp_data", in_data, e2);
      if (i == 1) begin
        D = 10'h155;
        D_vld = 1'b1;
      end
      @(posedge clk); #1;
      D_vld = 1'b0;
      D = '0;
    end
    check("ovf_set", err_ovf, 1'b1);
    in_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_valid", in_valid, 1'b0);
    check("bp_rel_rdy", D_rdy, 1'b1);
    send_frame(1'b0, e3, 6, 4'h0);
    frame_done(1'b0);

    fork
      begin
        tx_send({16'hFFFF, 16'h0000, 16'h8000, 16'h1234},
                {10'h3FF, 10'h3FF, 10'h000, 10'h000,
                 10'h3E0, 10'h000, 10'h004, 10'h234});
        tx_send({16'h0400, 16'h03FF, 16'h7FFF, 16'h0001},
                {10'h001, 10'h000, 10'h000, 10'h3FF,
                 10'h01F, 10'h3FF, 10'h000, 10'h001});
      end
      begin
        send_frame(1'b0, e4, 6, 4'h0);
        frame_done(1'b0);
      end
    join
    repeat (12) @(posedge clk); #1;
    check("tx_beats", zcnt, 16);
    check("tx_idle_vld", Z_vld, 1'b0);
    check("tx_idle_Z", Z, 10'd0);
    check("tx_idle_rdy", out_ready, 1'b1);
    check("tx_q_empty", tx_q.size(), 0);

    beat(10'h004);
    check("hdr_err", err_hdr, 1'b1);
    check("hdr_idle_rdy", D_rdy, 1'b1);
    check("hdr_no_valid", in_valid, 1'b0);
    send_frame(1'b0, e5, 6, 4'hF);
    frame_done(1'b0);

    beat(10'h000);
    beat(10'h001);
    beat(10'h000);
    beat(10'h002);
    beat(10'h000);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_rdy", D_rdy, 1'b1);
    check("mid_rst_valid", in_valid, 1'b0);
    check("mid_rst_err", {err_hdr, err_ovf}, 2'b00);
    send_frame(1'b0, e6, 6, 4'h0);
    frame_done(1'b0);

    repeat (3) @(posedge clk); #1;
    check("rx_q_empty", rx_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
